// File: rtl/jk_excitation_driver_if.sv
// Target handshake between sequencing control logic and the JK excitation driver.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             target_valid;
    logic [WIDTH-1:0] target;
    logic             target_ready;

    modport master (
        output target_valid,
        output target,
        input  target_ready
    );

    modport slave (
        input  target_valid,
        input  target,
        output target_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flip-flop bank toward a latched target, verifies Q and retries.
// state  | meaning
// IDLE   | ready for a target, j/k held at 0
// DRIVE  | j/k presented, bank samples them at the closing edge
// VERIFY | j/k back to 0, q_fb compared against target_reg at the closing edge
module jk_excitation_driver #(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jk_excitation_driver_if.slave  hs,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [WIDTH-1:0]       j,
    output logic [WIDTH-1:0]       k,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_reg, tgt_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic [RW-1:0]    retry_cnt, retry_nxt;
    logic             done_nxt, err_nxt;

    // Returns {j, k}; bits already at their target are held (J=K=0).
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] qc,
                                                  input logic [WIDTH-1:0] qt);
        logic [WIDTH-1:0] chg;
        chg = qc ^ qt;
        if (USE_TOGGLE != 0)
            return {chg, chg};
        else
            return {chg & qt, chg & ~qt};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt_reg   <= '0;
            retry_cnt <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt_reg   <= tgt_nxt;
            retry_cnt <= retry_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_reg;
        retry_nxt = retry_cnt;
        j_nxt     = '0;
        k_nxt     = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (hs.target_valid) begin
                    tgt_nxt        = hs.target;
                    {j_nxt, k_nxt} = excite(q_fb, hs.target);
                    retry_nxt      = '0;
                    state_nxt      = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = VERIFY;
            end
            VERIFY: begin
                if (q_fb == tgt_reg) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (retry_cnt < RMAX) begin
                    retry_nxt      = retry_cnt + RW'(1);
                    {j_nxt, k_nxt} = excite(q_fb, tgt_reg);
                    state_nxt      = DRIVE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign hs.target_ready = (state == IDLE);
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: set/reset and toggle variants, each driving its own JK bank.
module tb_jk_excitation_driver;
    logic       clk;
    logic       rst_n;
    logic [3:0] j0, k0, j1, k1;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [3:0] q0, q1, mask0, q_fb0, q_fb1;
    logic       ld;
    logic [3:0] ld_val;
    bit         sel;
    int         checks, errors;

    jk_excitation_driver_if #(.WIDTH(4)) if0 ();
    jk_excitation_driver_if #(.WIDTH(4)) if1 ();

    jk_excitation_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .hs(if0.slave), .q_fb(q_fb0),
        .j(j0), .k(k0), .busy(busy0), .done(done0), .err(err0));

    jk_excitation_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .hs(if1.slave), .q_fb(q_fb1),
        .j(j1), .k(k1), .busy(busy1), .done(done1), .err(err1));

    // JK flip-flop banks with a preload path; bank 0 can have bits stuck at 0 on its feedback.
    always_ff @(posedge clk) begin
        if (ld) begin
            q0 <= ld_val;
            q1 <= ld_val;
        end else begin
            q0 <= (j0 & ~q0) | (~k0 & q0);
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end
    assign q_fb0 = q0 & ~mask0;
    assign q_fb1 = q1;

    logic [3:0] sj, sk, sq;
    logic       sbusy, sdone, serr, sready;
    assign sj     = sel ? j1 : j0;
    assign sk     = sel ? k1 : k0;
    assign sq     = sel ? q_fb1 : q_fb0;
    assign sbusy  = sel ? busy1 : busy0;
    assign sdone  = sel ? done1 : done0;
    assign serr   = sel ? err1 : err0;
    assign sready = sel ? if1.target_ready : if0.target_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         tgl;
        logic [3:0] qi;
        logic [3:0] tgt;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [3:0] v);
        ld     = 1'b1;
        ld_val = v;
        cyc();
        ld     = 1'b0;
    endtask

    task automatic offer(input bit t, input logic v, input logic [3:0] d);
        if (t) begin
            if1.target_valid = v;
            if1.target       = d;
        end else begin
            if0.target_valid = v;
            if0.target       = d;
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        sel = v.tgl;
        preload(v.qi);
        offer(v.tgl, 1'b1, v.tgt);
        #1;
        chk($sformatf("v%0d_ready_idle", i), sready, 1'b1);
        cyc();
        offer(v.tgl, 1'b0, ~v.tgt);
        #1;
        chk($sformatf("v%0d_drive_busy", i), sbusy, 1'b1);
        chk($sformatf("v%0d_drive_ready", i), sready, 1'b0);
        chk($sformatf("v%0d_drive_j", i), sj, v.ej);
        chk($sformatf("v%0d_drive_k", i), sk, v.ek);
        cyc();
        chk($sformatf("v%0d_verify_jk", i), {sj, sk}, 8'h00);
        chk($sformatf("v%0d_verify_q", i), sq, v.eq);
        chk($sformatf("v%0d_verify_done", i), sdone, 1'b0);
        cyc();
        chk($sformatf("v%0d_done", i), sdone, 1'b1);
        chk($sformatf("v%0d_err", i), serr, 1'b0);
        chk($sformatf("v%0d_idle_busy", i), sbusy, 1'b0);
        chk($sformatf("v%0d_final_q", i), sq, v.eq);
        cyc();
        chk($sformatf("v%0d_done_pulse", i), sdone, 1'b0);
    endtask

    initial begin
        int busy_n, drv_n, err_n, done_n, ovl_n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ld     = 1'b0;
        ld_val = '0;
        mask0  = '0;
        sel    = 1'b0;
        offer(1'b0, 1'b0, 4'h0);
        offer(1'b1, 1'b0, 4'h0);

        vecs[0] = '{1'b0, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010};
        vecs[1] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        vecs[2] = '{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0101};
        vecs[3] = '{1'b0, 4'b0011, 4'b0110, 4'b0100, 4'b0001, 4'b0110};
        vecs[4] = '{1'b1, 4'b1100, 4'b0110, 4'b1010, 4'b1010, 4'b0110};
        vecs[5] = '{1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        vecs[6] = '{1'b1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b1001};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_jk0", {j0, k0}, 8'h00);
        chk("rst_jk1", {j1, k1}, 8'h00);
        chk("rst_flags0", {busy0, done0, err0}, 3'b000);
        chk("rst_flags1", {busy1, done1, err1}, 3'b000);
        chk("rst_ready0", if0.target_ready, 1'b1);
        chk("rst_ready1", if1.target_ready, 1'b1);
        @(negedge clk);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Stuck feedback bit: three DRIVE attempts then err.
        sel   = 1'b0;
        mask0 = 4'b0001;
        preload(4'b0000);
        offer(1'b0, 1'b1, 4'b0001);
        busy_n = 0; drv_n = 0; err_n = 0; done_n = 0; ovl_n = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            offer(1'b0, 1'b0, 4'b0000);
            #1;
            if (busy0) busy_n++;
            if (j0 == 4'b0001 && k0 == 4'b0000) drv_n++;
            if (err0) err_n++;
            if (done0) done_n++;
            if ((err0 || done0) && busy0) ovl_n++;
        end
        chk("stuck_busy_cycles", busy_n, 6);
        chk("stuck_drive_cycles", drv_n, 3);
        chk("stuck_err_pulses", err_n, 1);
        chk("stuck_done_pulses", done_n, 0);
        chk("stuck_flag_overlap", ovl_n, 0);
        mask0 = '0;

        // Back-to-back targets with valid held high; mid-operation target changes are ignored.
        preload(4'b0000);
        offer(1'b0, 1'b1, 4'h3);
        cyc();
        offer(1'b0, 1'b1, 4'hF);
        #1;
        chk("b2b_first_j", j0, 4'b0011);
        cyc();
        offer(1'b0, 1'b1, 4'hC);
        #1;
        chk("b2b_busy_ignore", {busy0, if0.target_ready}, 2'b10);
        cyc();
        chk("b2b_first_done", {done0, busy0, if0.target_ready}, 3'b101);
        chk("b2b_first_q", q_fb0, 4'h3);
        cyc();
        offer(1'b0, 1'b0, 4'h0);
        #1;
        chk("b2b_second_busy", busy0, 1'b1);
        chk("b2b_second_j", j0, 4'b1100);
        chk("b2b_second_k", k0, 4'b0011);
        cyc();
        cyc();
        chk("b2b_second_done", done0, 1'b1);
        chk("b2b_second_q", q_fb0, 4'hC);

        // Reset during DRIVE abandons the operation.
        cyc();
        preload(4'b0000);
        offer(1'b0, 1'b1, 4'hF);
        cyc();
        offer(1'b0, 1'b0, 4'h0);
        #1;
        chk("rstmid_drive_j", j0, 4'hF);
        rst_n = 1'b0;
        #1;
        chk("rstmid_jk", {j0, k0}, 8'h00);
        chk("rstmid_flags", {busy0, done0, err0}, 3'b000);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rstmid_ready", if0.target_ready, 1'b1);
        chk("rstmid_q_held", q_fb0, 4'h0);
        done_n = 0; err_n = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (done0) done_n++;
            if (err0) err_n++;
        end
        chk("rstmid_no_pulse", {done_n[7:0], err_n[7:0]}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
